// File: rtl/imem_loader_if.sv
// Loader bus: frame source handshake, start/status signals and the instruction-memory write port.
interface imem_loader_if #(
    parameter int ADDR_W = 5
);
    logic              ld_start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output ld_start, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, err
    );

    modport slave (
        input  ld_start, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Frame-based instruction-memory loader that holds the CPU in reset until a complete frame lands.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (adds the CHECK state).
module imem_loader #(
    parameter int ADDR_W = 5
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);
`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        CHECK = 3'd3,
        RUN   = 3'd4,
        ERR   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        RUN   = 3'd3,
        ERR   = 3'd4
    } state_t;
`endif

    state_t            state, state_next;
    logic [ADDR_W-1:0] idx, idx_next;
    logic [ADDR_W-1:0] last, last_next;
    logic [7:0]        csum, csum_next;
    logic [7:0]        len_m1;
    logic              accept;
    logic              len_bad;
    logic              write;
    logic              active_next;

    assign accept = bus.in_valid && bus.in_ready;
    assign len_m1 = bus.in_data - 8'd1;
    // A length above the memory depth shows up as bits set above the address range in N-1.
    assign len_bad = (bus.in_data == 8'd0) || (|(len_m1 >> ADDR_W));

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        state_next = state;
        idx_next   = idx;
        last_next  = last;
        csum_next  = csum;
        write      = 1'b0;

        case (state)
            IDLE, RUN, ERR: begin
                if (bus.ld_start) begin
                    state_next = LEN;
                    idx_next   = '0;
                    csum_next  = '0;
                end
            end
            LEN: begin
                if (accept) begin
                    if (len_bad) begin
                        state_next = ERR;
                    end else begin
                        last_next  = ADDR_W'(len_m1);
                        csum_next  = bus.in_data;
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    write     = 1'b1;
                    csum_next = csum ^ bus.in_data;
                    // Index stops at the last byte instead of wrapping past the top address.
                    if (idx == last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_next = CHECK;
`else
                        state_next = RUN;
`endif
                    end else begin
                        idx_next = idx + ADDR_W'(1);
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    state_next = (bus.in_data == csum) ? RUN : ERR;
                end
            end
`endif
            default: state_next = IDLE;
        endcase

        active_next = (state_next == LEN) || (state_next == DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        active_next = active_next || (state_next == CHECK);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            last           <= '0;
            csum           <= '0;
            bus.in_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            bus.cpu_reset  <= 1'b1;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            state          <= state_next;
            idx            <= idx_next;
            last           <= last_next;
            csum           <= csum_next;
            bus.in_ready   <= active_next;
            bus.busy       <= active_next;
            bus.cpu_reset  <= (state_next != RUN);
            bus.done       <= (state_next == RUN);
            bus.err        <= (state_next == ERR);
            bus.imem_we    <= write;
            if (write) begin
                bus.imem_addr  <= idx;
                bus.imem_wdata <= bus.in_data;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; checksum scenarios run when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
    localparam int ADDR_W = 5;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [7:0]        wr_data_q[$];
    int                wr_cyc_q[$];

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();
    imem_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr_q.push_back(bus.imem_addr);
            wr_data_q.push_back(bus.imem_wdata);
            wr_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; bus.ld_start = 1'b0; bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.ld_start = 1'b1;
        @(posedge clk);
        #1 bus.ld_start = 1'b0;
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    endtask

    // Offers one byte (after gap idle cycles) and returns 1ns after the edge that accepts it.
    task automatic send_byte(input logic [7:0] b, input int gap, input string tag);
        int budget = 20;
        if (gap > 0) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = b;
        while (bus.in_ready !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s_ready: in_ready=%b, required 1", tag, bus.in_ready);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input bq_t payload, input bit stall);
        logic [7:0] cs;
        cs = 8'(payload.size());
        send_byte(cs, 0, "len");
        foreach (payload[i]) begin
            send_byte(payload[i], stall ? int'($urandom_range(0, 2)) : 0, "data");
            cs = cs ^ payload[i];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(cs, 0, "csum");
`endif
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; bus.ld_start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h02;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        n_tests++; if (bus.imem_we !== 1'b0) begin n_fail++; $display("FAIL rst_imem_we: got %b want 0", bus.imem_we); end
        n_tests++; if (bus.imem_addr !== '0) begin n_fail++; $display("FAIL rst_imem_addr: got %h want 0", bus.imem_addr); end
        n_tests++; if (bus.imem_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_imem_wdata: got %h want 00", bus.imem_wdata); end
        n_tests++; if (bus.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_reset: got %b want 1", bus.cpu_reset); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.done); end
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.err); end
        @(negedge clk);
        reset = 1'b0; bus.ld_start = 1'b0; bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_tests++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_idle_hold: busy=%b in_ready=%b want 0 0", bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_d[2];
        exp_d = '{8'h40, 8'h7F};
        pulse_start();
        n_tests++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1 || bus.cpu_reset !== 1'b1) begin
            n_fail++; $display("FAIL basic_start: busy=%b in_ready=%b cpu_reset=%b want 1 1 1", bus.busy, bus.in_ready, bus.cpu_reset);
        end
        send_byte(8'h02, 0, "basic_len");
        send_byte(8'h40, 0, "basic_d0");
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h7F, 0, "basic_d1");
        n_tests++; if (bus.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL basic_hold: cpu_reset=%b want 1", bus.cpu_reset); end
        send_byte(8'h3D, 0, "basic_csum");
`else
        n_tests++; if (bus.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL basic_hold: cpu_reset=%b want 1", bus.cpu_reset); end
        send_byte(8'h7F, 0, "basic_d1");
`endif
        n_tests++; if (bus.cpu_reset !== 1'b0) begin n_fail++; $display("FAIL basic_release: cpu_reset=%b want 0", bus.cpu_reset); end
        n_tests++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL basic_status: done=%b busy=%b err=%b in_ready=%b want 1 0 0 0", bus.done, bus.busy, bus.err, bus.in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (wr_addr_q.size() != 2) begin n_fail++; $display("FAIL basic_count: got %0d writes want 2", wr_addr_q.size()); end
        foreach (exp_d[i]) begin
            n_tests++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== exp_d[i]) begin
                n_fail++; $display("FAIL basic_write%0d: want %0d:%h", i, i, exp_d[i]);
            end
        end
        n_tests++; if (wr_cyc_q.size() != 2 || wr_cyc_q[1] - wr_cyc_q[0] != 1) begin
            n_fail++; $display("FAIL basic_back_to_back: writes not in consecutive cycles (count %0d)", wr_cyc_q.size());
        end
        pulse_start();
        n_tests++; if (bus.cpu_reset !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_restart: cpu_reset=%b done=%b busy=%b want 1 0 1", bus.cpu_reset, bus.done, bus.busy);
        end
        do_reset();
    endtask

    task automatic test_bad_len();
        pulse_start();
        send_byte(8'h21, 0, "bad21_len");
        n_tests++; if (bus.err !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL bad21_status: err=%b in_ready=%b busy=%b want 1 0 0", bus.err, bus.in_ready, bus.busy);
        end
        n_tests++; if (bus.cpu_reset !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL bad21_cpu: cpu_reset=%b done=%b want 1 0", bus.cpu_reset, bus.done);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (wr_addr_q.size() != 0) begin n_fail++; $display("FAIL bad21_writes: got %0d want 0", wr_addr_q.size()); end
        pulse_start();
        n_tests++; if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL bad_restart: err=%b busy=%b want 0 1", bus.err, bus.busy);
        end
        send_byte(8'h00, 0, "bad00_len");
        n_tests++; if (bus.err !== 1'b1 || bus.in_ready !== 1'b0 || bus.cpu_reset !== 1'b1) begin
            n_fail++; $display("FAIL bad00_status: err=%b in_ready=%b cpu_reset=%b want 1 0 1", bus.err, bus.in_ready, bus.cpu_reset);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (wr_addr_q.size() != 0) begin n_fail++; $display("FAIL bad00_writes: got %0d want 0", wr_addr_q.size()); end
    endtask

    task automatic test_stall_full();
        bq_t payload;
        for (int i = 0; i < 32; i++) payload.push_back(8'(i * 37 + 5));
        pulse_start();
        send_frame(payload, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (bus.done !== 1'b1 || bus.cpu_reset !== 1'b0) begin
            n_fail++; $display("FAIL full_status: done=%b cpu_reset=%b want 1 0", bus.done, bus.cpu_reset);
        end
        n_tests++; if (wr_addr_q.size() != 32) begin n_fail++; $display("FAIL full_count: got %0d writes want 32", wr_addr_q.size()); end
        for (int i = 0; i < 32; i++) begin
            n_tests++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== 8'(i * 37 + 5)) begin
                n_fail++; $display("FAIL full_write%0d: want %0d:%h", i, i, 8'(i * 37 + 5));
            end
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_byte(8'h04, 0, "mid_len");
        send_byte(8'hA1, 0, "mid_d0");
        send_byte(8'hB2, 0, "mid_d1");
        @(negedge clk);
        reset = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hC3;
        @(posedge clk);
        #1;
        n_tests++; if (bus.in_ready !== 1'b0 || bus.imem_we !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_ctl: in_ready=%b imem_we=%b busy=%b want 0 0 0", bus.in_ready, bus.imem_we, bus.busy);
        end
        n_tests++; if (bus.imem_addr !== '0 || bus.imem_wdata !== 8'h00) begin
            n_fail++; $display("FAIL mid_rst_bus: addr=%h wdata=%h want 0 00", bus.imem_addr, bus.imem_wdata);
        end
        n_tests++; if (bus.cpu_reset !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_status: cpu_reset=%b done=%b err=%b want 1 0 0", bus.cpu_reset, bus.done, bus.err);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        n_tests++; if (wr_addr_q.size() != 2) begin n_fail++; $display("FAIL mid_count: got %0d writes want 2", wr_addr_q.size()); end
        n_tests++; if (wr_addr_q.size() < 2 || wr_data_q[0] !== 8'hA1 || wr_data_q[1] !== 8'hB2 || wr_addr_q[1] !== ADDR_W'(1)) begin
            n_fail++; $display("FAIL mid_data: first writes differ from 0:A1 1:B2");
        end
        n_tests++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_idle: in_ready=%b busy=%b want 0 0", bus.in_ready, bus.busy);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] exp_d[3];
        exp_d = '{8'h49, 8'h8A, 8'h1B};
        for (int pass = 0; pass < 2; pass++) begin
            pulse_start();
            send_byte(8'h03, 0, "cs_len");
            foreach (exp_d[i]) send_byte(exp_d[i], 0, "cs_data");
            n_tests++; if (bus.cpu_reset !== 1'b1) begin n_fail++; $display("FAIL cs%0d_hold: cpu_reset=%b want 1", pass, bus.cpu_reset); end
            send_byte((pass == 0) ? 8'hDB : 8'hDA, 0, "cs_sum");
            n_tests++;
            if (bus.done !== (pass == 0) || bus.err !== (pass == 1) || bus.cpu_reset !== (pass == 1)) begin
                n_fail++; $display("FAIL cs%0d_status: done=%b err=%b cpu_reset=%b want %0d %0d %0d",
                                   pass, bus.done, bus.err, bus.cpu_reset, pass == 0, pass == 1, pass == 1);
            end
            repeat (2) @(posedge clk);
            #1;
            n_tests++; if (wr_addr_q.size() != 3) begin n_fail++; $display("FAIL cs%0d_count: got %0d writes want 3", pass, wr_addr_q.size()); end
            foreach (exp_d[i]) begin
                n_tests++;
                if (i >= wr_addr_q.size() || wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== exp_d[i]) begin
                    n_fail++; $display("FAIL cs%0d_write%0d: want %0d:%h", pass, i, i, exp_d[i]);
                end
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        bus.ld_start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_basic();
        test_bad_len();
        test_stall_full();
        test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
